// File: rtl/aes_pkg.sv
// Shared types, FSM encoding and GF(2^8) arithmetic for the iterative AES-128 inverse cipher.
package aes_pkg;

    typedef logic [0:127] state_t;
    typedef logic [7:0]   byte_t;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_e;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end else begin
                p = p;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    // Byte 0 of the column sits in the top bits of the 32-bit word.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        byte_t a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box; row k of the table holds entries 16k..16k+15.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);

    localparam logic [0:2047] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = INV_SBOX_TABLE[{in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched from an external store.
module aes_inv_cipher_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic [3:0]   rk_idx,
    input  logic [0:127] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data
);

    fsm_e       fsm_q, fsm_d;
    logic [3:0] cnt_q, cnt_d;
    state_t     state_q, state_d;

    state_t     isr_s;
    state_t     isb_s;
    state_t     ark_s;
    state_t     imc_s;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = r + 4 * c;
            localparam int SRC = r + 4 * ((c - r + 4) % 4);
            assign isr_s[8*DST +: 8] = state_q[8*SRC +: 8];
            aes_inv_sbox u_inv_sbox (
                .in_byte  (isr_s[8*DST +: 8]),
                .out_byte (isb_s[8*DST +: 8])
            );
        end
        assign imc_s[32*c +: 32] = inv_mix_col(ark_s[32*c +: 32]);
    end

    assign ark_s = isb_s ^ rk_data;

    // Handshake, key index and output decode from the FSM and round counter.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = 4'd0;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                rk_idx   = 4'(NR);
            end
            ST_ROUND: rk_idx    = cnt_q;
            ST_DONE:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                rk_idx    = 4'd0;
            end
        endcase
    end

    assign out_data = state_q;

    // Next-state logic: initial AddRoundKey, nine full rounds, final round without InvMixColumns.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = in_data ^ rk_data;
                    cnt_d   = 4'(NR - 1);
                    fsm_d   = ST_ROUND;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (cnt_q == 4'd0) begin
                    state_d = ark_s;
                    fsm_d   = ST_DONE;
                end else begin
                    state_d = imc_s;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end else begin
                    fsm_d = ST_DONE;
                end
            end
            default: begin
                fsm_d   = ST_IDLE;
                cnt_d   = 4'd0;
                state_d = '0;
            end
        endcase
    end

    // State, counter and FSM registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            cnt_q   <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter: directed FIPS-197 checks plus random encrypt/decrypt round trips.
module tb_aes_inv_cipher_iter;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    int           total = 0;
    int           bad   = 0;
    logic [127:0] rkeys [0:10];
    logic [127:0] exp_q [$];
    logic [7:0]   sb    [0:255];
    logic         rand_mode = 1'b0;
    logic         ready_ovr = 1'b0;

    aes_inv_cipher_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rk_data = 128'h0;
        if (rk_idx <= 4'd10) rk_data = rkeys[rk_idx];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (forward cipher) ----------------
    function automatic logic [7:0] m_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = m_xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int k);
        return s[127-8*k -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = m_xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rkeys[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[127-8*(r+4*c) -: 8] = sb[gb(s, r + 4*((c + r) % 4))];
            s = t;
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
                    t[127-32*c -: 32] = {m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3,
                                         a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3,
                                         a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03),
                                         m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02)};
                end
                s = t;
            end
            s = s ^ rkeys[rnd];
        end
        return s;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = m_mul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sb[x] = b ^ 8'h63;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic wait_in_ready();
        int n = 0;
        while (!in_ready && n < 60) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {127'h0, in_ready}, 128'h1);
    endtask

    task automatic issue(input logic [127:0] ct);
        wait_in_ready();
        in_data  = ct;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: choose out_ready, then pop and compare on every output handshake.
    initial begin
        logic [127:0] e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_ovr;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", out_data, 128'h0);
                    if (out_data == 128'h0) begin
                        bad++;
                        $display("FAIL unexpected_output: got output with empty scoreboard");
                    end
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                end
            end
        end
    end

    initial begin
        logic [127:0] key, pt, ct;
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 128'h0;
        for (int r = 0; r <= 10; r++) rkeys[r] = 128'h0;
        build_sbox();
        tick();
        tick();
        rst = 1'b0;

        chk("reset_in_ready",  {127'h0, in_ready},  128'h1);
        chk("reset_out_valid", {127'h0, out_valid}, 128'h0);
        chk("reset_rk_idx",    {124'h0, rk_idx},    128'd10);
        chk("reset_out_data",  out_data,            128'h0);

        // FIPS-197 C.1 with rk_idx trace, latency and back-pressure.
        expand_key(C1_KEY);
        ready_ovr = 1'b0;
        exp_q.push_back(C1_PT);
        issue(C1_CT);
        for (int i = 9; i >= 0; i--) begin
            chk("rk_idx_trace", {124'h0, rk_idx}, 128'(i));
            chk("round_in_ready", {127'h0, in_ready | out_valid}, 128'h0);
            tick();
        end
        chk("c1_out_valid_cycle11", {127'h0, out_valid}, 128'h1);
        chk("done_rk_idx", {124'h0, rk_idx}, 128'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", {127'h0, out_valid}, 128'h1);
            chk("bp_out_data",  out_data, C1_PT);
            chk("bp_in_ready",  {127'h0, in_ready}, 128'h0);
        end
        ready_ovr = 1'b1;
        tick();
        chk("post_hs_out_valid", {127'h0, out_valid}, 128'h0);
        chk("post_hs_in_ready",  {127'h0, in_ready},  128'h1);

        // in_valid held with other data during ROUND must be ignored.
        exp_q.push_back(C1_PT);
        issue(C1_CT);
        in_valid = 1'b1;
        in_data  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        for (int i = 0; i < 10; i++) tick();
        chk("hold_out_valid", {127'h0, out_valid}, 128'h1);
        in_valid = 1'b0;
        tick();

        // Reset mid-ROUND discards the block.
        issue(C1_CT);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_rk_idx", {124'h0, rk_idx}, 128'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("rst_in_ready",  {127'h0, in_ready},  128'h1);
        chk("rst_out_data",  out_data, 128'h0);

        // Reset wins over a simultaneous handshake.
        in_data  = C1_CT;
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_prio_in_ready", {127'h0, in_ready}, 128'h1);
        chk("rst_prio_rk_idx",   {124'h0, rk_idx},   128'd10);

        exp_q.push_back(C1_PT);
        issue(C1_CT);
        for (int i = 0; i < 10; i++) tick();
        chk("fresh_out_valid", {127'h0, out_valid}, 128'h1);

        // Random round trips with random back-pressure.
        rand_mode = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            wait_in_ready();
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            ct = encrypt(pt);
            exp_q.push_back(pt);
            in_data  = ct;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk("drain_scoreboard", 128'(exp_q.size()), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit, single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit, reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit, ciphertext offered.
REQ-004 SHALL have port in_ready, output, 1 bit, block can accept ciphertext.
REQ-005 SHALL have port in_data, input, [0:127], ciphertext; byte k = bits [8k:8k+7], bytes column-major (bytes 0-3 = column 0).
REQ-006 SHALL have port rk_idx, output, [3:0], round-key index requested from the external key store.
REQ-007 SHALL have port rk_data, input, [0:127], round key for rk_idx, valid combinationally in the same cycle; same byte order as in_data.
REQ-008 SHALL have port out_valid, output, 1 bit, plaintext available.
REQ-009 SHALL have port out_ready, input, 1 bit, consumer accepts plaintext.
REQ-010 SHALL have port out_data, output, [0:127], plaintext, same byte order.

Function
REQ-011 SHALL implement the AES-128 inverse cipher iteratively, one round per clock, using externally supplied round keys 0..10.
REQ-012 SHALL use FSM states IDLE, ROUND, DONE.
REQ-013 IDLE: in_ready=1, rk_idx=10. On in_valid&in_ready, state register <= in_data XOR rk_data, round counter <= 9, go to ROUND.
REQ-014 ROUND: in_ready=0, rk_idx=round counter. For counter 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk_data), counter decrements.
REQ-015 ROUND with counter 0: state <= InvSubBytes(InvShiftRows(state)) XOR rk_data, no InvMixColumns, go to DONE.
REQ-016 InvShiftRows: out byte (r+4c) = in byte (r+4*((c-r) mod 4)), r,c in 0..3; e.g. out[1]=in[13], out[5]=in[1], out[2]=in[10], out[3]=in[7].
REQ-017 InvMixColumns: per column, GF(2^8) multiply by {0e,0b,0d,09} circulant, reduction polynomial 0x11B.
REQ-018 DONE: out_valid=1, out_data=state register, in_ready=0. Stays in DONE with out_data stable until out_valid&out_ready, then goes to IDLE.
REQ-019 Latency: handshake in cycle 0; out_valid first high in cycle 11. Next ciphertext accepted no earlier than the cycle after output handshake.
REQ-020 in_valid while not IDLE is ignored. in_data is sampled only at the handshake edge.
REQ-021 rk_idx SHALL be a pure function of FSM state and counter. In DONE it is 0.
REQ-022 out_valid SHALL NOT depend combinationally on out_ready.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, counter=0, state register=0, out_valid=0, from any state including mid-ROUND. The in-flight block is discarded and no partial output is produced.
REQ-024 During the first cycle after reset deasserts: in_ready=1, rk_idx=10, out_data=0.
REQ-025 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-026 Package aes_pkg SHALL hold: state typedef [0:127], byte typedef, NR=10, the FSM state enum, and the GF xtime/multiply functions.
REQ-027 InvSubBytes SHALL use sub-module aes_inv_sbox (8-bit combinational inverse S-box lookup), instantiated 16 times.
REQ-028 InvShiftRows, InvMixColumns and AddRoundKey SHALL be combinational inside the block. The only registers are state, counter and FSM.

Verification
REQ-029 FIPS-197 C.1: key 000102..0f schedule driven by the bench, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff with out_valid in cycle 11.
REQ-030 rk_idx trace for one block SHALL be 10 in cycle 0, then 9,8,...,0 in cycles 1-10, then 0 in DONE.
REQ-031 Back-pressure: out_ready=0 for 5 cycles after out_valid -> out_valid and out_data stable, in_ready=0; out_ready=1 -> IDLE and in_ready=1 next cycle.
REQ-032 rst pulse at cycle 5 of a decryption -> out_valid=0 and in_ready=1 next cycle; a fresh vector then decrypts correctly.
REQ-033 in_valid held high with a different ciphertext during ROUND -> ignored; the first result still matches the golden value.
REQ-034 Random: 1000 random key/plaintext pairs; the bench encrypts with a reference model -> decrypted out_data equals the original plaintext, back-to-back with random out_ready.
